// File: rtl/fetch_run_controller.sv
// Run/step/halt sequencer for the fetch stage: gates PC commits via o_run and
// stops on Stop, halt instruction, PC breakpoint or a cumulative commit limit.
module fetch_run_controller #(
   parameter int          PC_W      = 30,
   parameter int          CNT_W     = 32,
   parameter logic [31:0] HALT_INSN = 32'h0000000C
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_step_req,
   input  logic [PC_W-1:0]  i_pc,
   input  logic [31:0]      i_instruction,
   input  logic             i_bp_enable,
   input  logic [PC_W-1:0]  i_bp_addr,
   input  logic [CNT_W-1:0] i_cycle_limit,
   output logic             o_run,
   output logic             o_halted,
   output logic [1:0]       o_state,
   output logic [2:0]       o_halt_cause,
   output logic [CNT_W-1:0] o_instr_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2,
      S_HALT = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      C_NONE  = 3'd0,
      C_STOP  = 3'd1,
      C_INSN  = 3'd2,
      C_BREAK = 3'd3,
      C_LIMIT = 3'd4,
      C_STEP  = 3'd5
   } cause_t;

   state_t           r_state;
   cause_t           r_cause;
   logic [CNT_W-1:0] r_count;
   logic             r_run;
   logic             r_halted;

   state_t w_next;
   cause_t w_cause;
   logic   w_is_halt_insn;
   logic   w_bp_hit;
   logic   w_limit_hit;
   logic   w_commit;

   assign w_is_halt_insn = (i_instruction == HALT_INSN);
   assign w_bp_hit       = i_bp_enable && (i_pc == i_bp_addr);
   assign w_limit_hit    = (i_cycle_limit != '0) && (r_count == i_cycle_limit);
   assign w_commit       = (w_next == S_RUN) || (w_next == S_STEP);

   always_comb begin
      w_next  = r_state;
      w_cause = r_cause;
      case (r_state)
         S_IDLE, S_HALT: begin
            // A halt instruction is terminal: only Reset leaves this state.
            if (r_state == S_HALT && r_cause == C_INSN) begin
               w_next = S_HALT;
            end else if (i_stop) begin
               w_next  = S_HALT;
               w_cause = C_STOP;
            end else if (i_start || i_step_req) begin
               // No breakpoint check here so a run can resume off a breakpoint.
               if (w_is_halt_insn) begin
                  w_next  = S_HALT;
                  w_cause = C_INSN;
               end else if (w_limit_hit) begin
                  w_next  = S_HALT;
                  w_cause = C_LIMIT;
               end else if (i_start) begin
                  w_next = S_RUN;
               end else begin
                  w_next = S_STEP;
               end
            end
         end
         S_RUN: begin
            if (i_stop) begin
               w_next  = S_HALT;
               w_cause = C_STOP;
            end else if (w_is_halt_insn) begin
               w_next  = S_HALT;
               w_cause = C_INSN;
            end else if (w_bp_hit) begin
               w_next  = S_HALT;
               w_cause = C_BREAK;
            end else if (w_limit_hit) begin
               w_next  = S_HALT;
               w_cause = C_LIMIT;
            end
         end
         S_STEP: begin
            w_next  = S_HALT;
            w_cause = i_stop ? C_STOP : C_STEP;
         end
         default: begin
            w_next  = S_IDLE;
            w_cause = C_NONE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_cause  <= C_NONE;
         r_count  <= '0;
         r_run    <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_cause  <= w_cause;
         r_run    <= w_commit;
         r_halted <= (w_next == S_HALT);
         if (w_commit && !(&r_count))
            r_count <= r_count + 1'b1;
      end
   end

   assign o_run         = r_run;
   assign o_halted      = r_halted;
   assign o_state       = r_state;
   assign o_halt_cause  = r_cause;
   assign o_instr_count = r_count;

endmodule
